bcd_disp_scan: RTL and testbench
================================

BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles per digit slot (legal range 1..2^20).
REQ-002 The block SHALL have parameter DP_DIGIT, default 4, giving the digit index whose decimal point is lit (0..3); 4 means no decimal point.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port bcd_in, input, 16 bits: packed BCD value from the frequency counter latch, [3:0] units through [15:12] thousands.
REQ-006 The block SHALL have port an, output, 4 bits: active-low digit enables, with an[i] driving digit i.
REQ-007 The block SHALL have port seg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse each time a new snapshot is taken.

Function
REQ-010 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL be asserted in the cycle the count equals SCAN_DIV-1; with SCAN_DIV=1, tick SHALL be asserted every cycle.
REQ-011 The digit index idx SHALL advance 0->1->2->3->0 on each tick.
REQ-012 On a tick with idx=3, snap SHALL load bcd_in and frame_done SHALL pulse in the following cycle, so that one frame always shows one consistent value.
REQ-013 bcd_in SHALL NOT affect outputs except through snap; bcd_in changes mid-frame SHALL be invisible until the next frame.
REQ-014 The outputs an, seg and dp SHALL be registered, with one cycle of latency from an idx or snap change.
REQ-015 an SHALL drive exactly one bit low, the bit at position idx, except in reset.
REQ-016 Digit decode (active-low gfedcba) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 An illegal nibble (10..15) SHALL display E=0000110, and leading-zero blanking SHALL treat it as nonzero.
REQ-018 dp SHALL be 0 only while idx==DP_DIGIT and SHALL be 1 otherwise.
REQ-019 A blanked digit SHALL drive seg=1111111 and dp=1, while its an bit still goes low in its slot.

Reset
REQ-020 While rst=0, the block SHALL hold prescaler=0, idx=0, snap=16'h0000, an=1111, seg=1111111, dp=1 and frame_done=0.
REQ-021 On rst release, scanning SHALL start at digit 0 showing snap=0, with the first snapshot taken at the first tick with idx=3.
REQ-022 Assertion of rst mid-frame SHALL immediately force the reset values, with no partial-frame completion.

Configuration
REQ-023 When macro DISP_LZ_BLANK_EN is defined, digit i (i=3..1) SHALL be blanked when all snap nibbles from 3 down to i are 0; digit 0 SHALL never be blanked.
REQ-024 When DISP_LZ_BLANK_EN is undefined, all four digits SHALL always be decoded, and leading zeros SHALL be shown as 0.
REQ-025 dp forcing on DP_DIGIT SHALL override blanking, in which case seg stays blank and dp=0.

Verification (SCAN_DIV=4 unless noted)
REQ-026 Reset held for 10 cycles, then released -> an=1111 and seg=1111111 during reset; an=1110 and seg=1000000 from the second cycle after release.
REQ-027 bcd_in=16'h1234 applied -> after the first snapshot, frame_done pulses once, and slots 0..3 show seg 0011001, 0110000, 0100100, 1111001 with an 1110, 1101, 1011, 0111, each for 4 cycles.
REQ-028 bcd_in=16'h0050 with DISP_LZ_BLANK_EN defined -> digits 3 and 2 show 1111111, digit 1 shows 0010010 and digit 0 shows 1000000; without the macro, digits 3 and 2 show 1000000.
REQ-029 bcd_in changed from 16'h1111 to 16'h2222 during slot 1 -> the remaining slots of that frame show 1, and the next frame shows 2 after the frame_done pulse.
REQ-030 bcd_in=16'h00A0 with DISP_LZ_BLANK_EN defined -> digit 1 shows E=0000110 and digits 3 and 2 are blanked.
REQ-031 SCAN_DIV=1 and DP_DIGIT=2, with rst asserted mid-frame -> idx changes every cycle, dp=0 only in the slot where an=1011, and reset forces an=1111 within the same cycle.

Source files
------------

// File: rtl/bcd_disp_scan.sv
// Four-digit multiplexed 7-segment driver: scans a frame-stable BCD snapshot.
// Define DISP_LZ_BLANK_EN to enable leading-zero blanking of digits 3..1.
module bcd_disp_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DP_DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              CW   = 20;
  localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic          w_dp_on;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;

  // Active-low gfedcba pattern; anything outside 0..9 shows 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0000110;
    endcase
    return pat;
  endfunction

  assign w_tick      = (r_presc == LAST);
  assign w_frame_end = w_tick && (r_idx == 2'd3);
  assign w_an        = 4'b1111 ^ (4'b0001 << r_idx);
  assign w_dp_on     = (int'(r_idx) == DP_DIGIT);

  // Select the nibble for the current slot and decide whether it is a leading zero.
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0:    w_nib = r_snap[3:0];
      2'd1:    w_nib = r_snap[7:4];
      2'd2:    w_nib = r_snap[11:8];
      2'd3:    w_nib = r_snap[15:12];
      default: w_nib = 4'd0;
    endcase
`ifdef DISP_LZ_BLANK_EN
    case (r_idx)
      2'd1:    w_blank = (r_snap[15:4]  == 12'd0);
      2'd2:    w_blank = (r_snap[15:8]  == 8'd0);
      2'd3:    w_blank = (r_snap[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank = 1'b0;
`endif
    w_seg = w_blank ? 7'b1111111 : seg_decode(w_nib);
  end

  // Slot timing and the per-frame snapshot of the input value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_snap       <= 16'h0000;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? {CW{1'b0}} : r_presc + {{(CW-1){1'b0}}, 1'b1};
      r_idx        <= w_tick ? r_idx + 2'd1 : r_idx;
      r_snap       <= w_frame_end ? bcd_in : r_snap;
      r_frame_done <= w_frame_end;
    end
  end

  // Registered display drive; the decimal point ignores blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp_on ? 1'b0 : 1'b1;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Self-checking bench for bcd_disp_scan: vector table, hand sequences and a
// randomized run against a cycle-index arithmetic reference model.
module tb_bcd_disp_scan;

`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] ZL = LZ ? 7'b1111111 : 7'b1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;

  int n_pass = 0;
  int n_total = 0;
  int n = 0;
  logic [15:0] hist [0:8191];

  bcd_disp_scan #(.SCAN_DIV(4), .DP_DIGIT(4)) u_a (
    .clk(clk), .rst(rst), .bcd_in(bcd_in),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

  bcd_disp_scan #(.SCAN_DIV(1), .DP_DIGIT(2)) u_b (
    .clk(clk), .rst(rst), .bcd_in(bcd_in),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0][6:0] segs;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
            7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
    return tbl[d];
  endfunction

  // Expected outputs after edge k of the current reset-free run, from plain arithmetic.
  task automatic model(input int k, input int d, input int dpd,
                       output logic [3:0] e_an, output logic [6:0] e_seg,
                       output logic e_dp, output logic e_fd);
    int idx, m;
    logic [15:0] snap, upper;
    if (k == 0) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      idx   = ((k - 1) / d) % 4;
      m     = ((k - 1) / (4 * d)) * (4 * d);
      snap  = (m == 0) ? 16'h0000 : hist[m];
      upper = snap >> (4 * idx);
      e_an  = 4'b1111 ^ (4'b0001 << idx);
      e_seg = (LZ && idx > 0 && upper == 16'h0000) ? 7'b1111111 : ref_seg(upper[3:0]);
      e_dp  = (idx == dpd) ? 1'b0 : 1'b1;
      e_fd  = (k % (4 * d) == 0);
    end
  endtask

  task automatic check_model();
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_fd;
    model(n, 4, 4, e_an, e_seg, e_dp, e_fd);
    chk("a_an", {12'd0, an_a}, {12'd0, e_an});
    chk("a_seg", {9'd0, seg_a}, {9'd0, e_seg});
    chk("a_dp", {15'd0, dp_a}, {15'd0, e_dp});
    chk("a_fd", {15'd0, fd_a}, {15'd0, e_fd});
    model(n, 1, 2, e_an, e_seg, e_dp, e_fd);
    chk("b_an", {12'd0, an_b}, {12'd0, e_an});
    chk("b_seg", {9'd0, seg_b}, {9'd0, e_seg});
    chk("b_dp", {15'd0, dp_b}, {15'd0, e_dp});
    chk("b_fd", {15'd0, fd_b}, {15'd0, e_fd});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst && n < 8191) begin
      n++;
      hist[n] = bcd_in;
    end
    #1;
    check_model();
  endtask

  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = fd_a;
    end
    chk("fd_timeout", {15'd0, seen}, 16'd1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_an_a", {12'd0, an_a}, 16'h000F);
    chk("rst_an_b", {12'd0, an_b}, 16'h000F);
    chk("rst_seg_a", {9'd0, seg_a}, 16'h007F);
    chk("rst_fd_a", {15'd0, fd_a}, 16'd0);
    n = 0;
  endtask

  vec_t tbl [7];
  logic [3:0] prev_an_b;

  initial begin
    tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{16'h0050, {ZL, ZL, 7'b0010010, 7'b1000000}};
    tbl[2] = '{16'h00A0, {ZL, ZL, 7'b0000110, 7'b1000000}};
    tbl[3] = '{16'h9876, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}};
    tbl[4] = '{16'h0000, {ZL, ZL, ZL, 7'b1000000}};
    tbl[5] = '{16'hF00B, {7'b0000110, 7'b1000000, 7'b1000000, 7'b0000110}};
    tbl[6] = '{16'h0100, {ZL, 7'b1111001, 7'b1000000, 7'b1000000}};

    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    step();
    chk("rel_an", {12'd0, an_a}, 16'h000E);
    chk("rel_seg", {9'd0, seg_a}, 16'h0040);

    // Table: each value appears for a full frame after its snapshot.
    for (int v = 0; v < 7; v++) begin
      bcd_in = tbl[v].bcd;
      wait_fd();
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          step();
          chk($sformatf("tbl%0d_an%0d", v, s), {12'd0, an_a},
              {12'd0, 4'b1111 ^ (4'b0001 << s)});
          chk($sformatf("tbl%0d_seg%0d", v, s), {9'd0, seg_a}, {9'd0, tbl[v].segs[s]});
        end
      end
    end

    // Input change mid-frame stays hidden until the next snapshot.
    bcd_in = 16'h1111;
    wait_fd();
    for (int c = 0; c < 5; c++) step();
    bcd_in = 16'h2222;
    for (int c = 0; c < 11; c++) begin
      step();
      chk("mid_old", {9'd0, seg_a}, 16'h0079);
    end
    chk("mid_fd", {15'd0, fd_a}, 16'd1);
    step();
    chk("mid_new", {9'd0, seg_a}, 16'h0024);

    // Randomized run with one asynchronous reset in the middle.
    prev_an_b = an_b;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 9) == 0)
        bcd_in = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
      if (c == 350) begin
        async_reset();
        for (int r = 0; r < 3; r++) step();
        rst = 1'b1;
      end
      step();
      if (n >= 2) begin
        chk("b_idx_moves", {15'd0, an_b != prev_an_b}, 16'd1);
        chk("b_dp_slot", {15'd0, dp_b}, {15'd0, an_b != 4'b1011});
      end
      prev_an_b = an_b;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
